// File: rtl/boot_sequencer.sv
// boot_sequencer: copies a program image from a valid/ready source stream into
// instruction memory, starting at address 0. The end of the image is an end
// marker word or src_last. The CPU is then held in reset for HOLD_CYCLES and
// released.
// Optional feature: define BOOT_CHECKSUM_EN to require a trailing checksum word
// that must equal the running sum of all written words.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start after reset
// LOAD  | accepting image words and writing them to memory
// CHECK | waiting for the checksum word (BOOT_CHECKSUM_EN only)
// HOLD  | image complete, CPU kept in reset for the settle time
// RUN   | CPU released; terminal until reset_n
// ERROR | empty image, overflow or bad checksum; start retries the load
module boot_sequencer #(
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] END_MARKER  = 32'hFFFFFFFF,
  parameter int                    HOLD_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  input  logic                  src_last,
  output logic                  src_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_reset_n,
  output logic                  cpu_run,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0]       HOLD_LOAD = CW'(HOLD_CYCLES);
  localparam logic [ADDR_WIDTH:0] FULL      = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
`ifdef BOOT_CHECKSUM_EN
    S_CHECK = 3'd2,
`endif
    S_HOLD  = 3'd3,
    S_RUN   = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           hold_cnt, hold_cnt_nxt;
  logic                    src_ready_nxt, mem_we_nxt, cpu_reset_n_nxt, cpu_run_nxt;
  logic                    busy_nxt, done_nxt, error_nxt;
  logic [ADDR_WIDTH-1:0]   mem_addr_nxt;
  logic [DATA_WIDTH-1:0]   mem_wdata_nxt;
  logic [ADDR_WIDTH:0]     word_count_nxt;
  logic                    xfer, is_marker, term;
`ifdef BOOT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]   sum, sum_nxt;
`endif

  assign xfer      = src_valid & src_ready;
  assign is_marker = (src_data == END_MARKER);

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    state_nxt       = state;
    hold_cnt_nxt    = hold_cnt;
    src_ready_nxt   = src_ready;
    mem_we_nxt      = 1'b0;
    mem_addr_nxt    = mem_addr;
    mem_wdata_nxt   = mem_wdata;
    cpu_reset_n_nxt = cpu_reset_n;
    cpu_run_nxt     = cpu_run;
    busy_nxt        = busy;
    done_nxt        = done;
    error_nxt       = error;
    word_count_nxt  = word_count;
    term            = 1'b0;
`ifdef BOOT_CHECKSUM_EN
    sum_nxt         = sum;
`endif

    case (state)
      S_IDLE, S_ERROR: begin
        if (start) begin
          state_nxt      = S_LOAD;
          src_ready_nxt  = 1'b1;
          busy_nxt       = 1'b1;
          error_nxt      = 1'b0;
          word_count_nxt = '0;
          mem_addr_nxt   = '0;
`ifdef BOOT_CHECKSUM_EN
          sum_nxt        = '0;
`endif
        end
      end

      S_LOAD: begin
        if (xfer) begin
          if (is_marker) begin
            if (word_count == '0) begin
              state_nxt     = S_ERROR;
              src_ready_nxt = 1'b0;
              busy_nxt      = 1'b0;
              error_nxt     = 1'b1;
            end else begin
              term = 1'b1;
            end
          end else if (word_count == FULL) begin
            // No room left: the word is dropped, not wrapped onto address 0.
            state_nxt     = S_ERROR;
            src_ready_nxt = 1'b0;
            busy_nxt      = 1'b0;
            error_nxt     = 1'b1;
          end else begin
            mem_we_nxt     = 1'b1;
            mem_addr_nxt   = word_count[ADDR_WIDTH-1:0];
            mem_wdata_nxt  = src_data;
            word_count_nxt = word_count + (ADDR_WIDTH+1)'(1);
`ifdef BOOT_CHECKSUM_EN
            sum_nxt        = sum + src_data;
`endif
            term           = src_last;
          end
        end
      end

`ifdef BOOT_CHECKSUM_EN
      S_CHECK: begin
        if (xfer) begin
          src_ready_nxt = 1'b0;
          if (src_data == sum) begin
            state_nxt    = S_HOLD;
            hold_cnt_nxt = HOLD_LOAD;
          end else begin
            state_nxt = S_ERROR;
            busy_nxt  = 1'b0;
            error_nxt = 1'b1;
          end
        end
      end
`endif

      S_HOLD: begin
        // The counter reaches zero one cycle before release, giving
        // HOLD_CYCLES+1 edges from the terminating handshake.
        if (hold_cnt == '0) begin
          state_nxt       = S_RUN;
          cpu_reset_n_nxt = 1'b1;
          cpu_run_nxt     = 1'b1;
          done_nxt        = 1'b1;
          busy_nxt        = 1'b0;
        end else begin
          hold_cnt_nxt = hold_cnt - CW'(1);
        end
      end

      S_RUN: begin
      end

      default: state_nxt = S_IDLE;
    endcase

    if (term) begin
`ifdef BOOT_CHECKSUM_EN
      state_nxt     = S_CHECK;
      src_ready_nxt = 1'b1;
`else
      state_nxt     = S_HOLD;
      src_ready_nxt = 1'b0;
      hold_cnt_nxt  = HOLD_LOAD;
`endif
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      hold_cnt    <= '0;
      src_ready   <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_reset_n <= 1'b0;
      cpu_run     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      word_count  <= '0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_cnt_nxt;
      src_ready   <= src_ready_nxt;
      mem_we      <= mem_we_nxt;
      mem_addr    <= mem_addr_nxt;
      mem_wdata   <= mem_wdata_nxt;
      cpu_reset_n <= cpu_reset_n_nxt;
      cpu_run     <= cpu_run_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      error       <= error_nxt;
      word_count  <= word_count_nxt;
    end
  end

`ifdef BOOT_CHECKSUM_EN
  // Running checksum of written words, modulo 2**DATA_WIDTH.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sum <= '0;
    else          sum <= sum_nxt;
  end
`endif

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer with ADDR_WIDTH=2 so overflow is reachable.
// Builds with or without BOOT_CHECKSUM_EN; with it, each good image is followed
// by its checksum word.
module tb_boot_sequencer;
  localparam int          AW   = 2;
  localparam int          HOLD = 4;
  localparam logic [31:0] MARK = 32'hFFFFFFFF;
`ifdef BOOT_CHECKSUM_EN
  localparam logic        RDY_AFTER_TERM = 1'b1;
`else
  localparam logic        RDY_AFTER_TERM = 1'b0;
`endif

  logic          clock = 1'b0, reset_n = 1'b1, start = 1'b0;
  logic          src_valid = 1'b0, src_last = 1'b0;
  logic [31:0]   src_data = '0;
  logic          src_ready, mem_we, cpu_reset_n, cpu_run, busy, done, error;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   word_count;

  int   errors = 0, checks = 0, cyc = 0, wr_count = 0, rise_edge = -1, hs_edge = 0;
  logic prev_rst = 1'b0;

  boot_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .END_MARKER(MARK), .HOLD_CYCLES(HOLD)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .src_valid(src_valid),
    .src_data(src_data), .src_last(src_last), .src_ready(src_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_reset_n(cpu_reset_n),
    .cpu_run(cpu_run), .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // Count writes and record the edge at which cpu_reset_n rises.
  always @(negedge clock) begin
    if (mem_we === 1'b1) wr_count++;
    if (cpu_reset_n === 1'b1 && prev_rst !== 1'b1) rise_edge = cyc;
    prev_rst = cpu_reset_n;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input logic [31:0] d, input logic l, input logic we,
                      input logic [AW-1:0] a, input string tag);
    int n = 0;
    src_valid = 1'b1; src_data = d; src_last = l;
    while (src_ready !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    check({tag, "_ready"}, 64'(src_ready), 64'd1);
    @(negedge clock);
    hs_edge = cyc;
    src_valid = 1'b0; src_last = 1'b0;
    check({tag, "_we"}, 64'(mem_we), 64'(we));
    if (we) begin
      check({tag, "_addr"}, 64'(mem_addr), 64'(a));
      check({tag, "_data"}, 64'(mem_wdata), 64'(d));
    end
  endtask

  task automatic start_load(input string tag);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_rdy"}, 64'(src_ready), 64'd1);
    check({tag, "_wc0"}, 64'(word_count), 64'd0);
    check({tag, "_err0"}, 64'(error), 64'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    wr_count = 0;
    rise_edge = -1;
    @(negedge clock);
  endtask

  task automatic finish_ok(input logic [31:0] sum, input string tag);
    int n = 0;
`ifdef BOOT_CHECKSUM_EN
    send(sum, 1'b0, 1'b0, '0, {tag, "_cks"});
`else
    sum = sum;
`endif
    while (done !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    @(negedge clock);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_rise"}, 64'(rise_edge), 64'(hs_edge + 1 + HOLD));
    check({tag, "_run"}, 64'(cpu_run), 64'd1);
    check({tag, "_cpurst"}, 64'(cpu_reset_n), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int snap;
    // Reset values
    #2 reset_n = 1'b0;
    #1;
    check("rst_ready", 64'(src_ready), 64'd0);
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    check("rst_cpurst", 64'(cpu_reset_n), 64'd0);
    check("rst_run", 64'(cpu_run), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_wc", 64'(word_count), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Asynchronous reset in the middle of a load
    start_load("ml");
    send(32'h5, 1'b0, 1'b1, 2'd0, "ml0");
    src_valid = 1'b1; src_data = 32'h6;
    #2 reset_n = 1'b0;
    #1;
    check("ml_we", 64'(mem_we), 64'd0);
    check("ml_rdy", 64'(src_ready), 64'd0);
    check("ml_busy", 64'(busy), 64'd0);
    check("ml_wc", 64'(word_count), 64'd0);
    check("ml_wdata", 64'(mem_wdata), 64'd0);
    snap = wr_count;
    repeat (3) @(negedge clock);
    check("ml_nowr", 64'(wr_count), 64'(snap));
    src_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);

    // Three words then end marker
    do_reset();
    start_load("s2");
    send(32'h11, 1'b0, 1'b1, 2'd0, "s2w0");
    send(32'h22, 1'b0, 1'b1, 2'd1, "s2w1");
    send(32'h33, 1'b0, 1'b1, 2'd2, "s2w2");
    send(MARK, 1'b0, 1'b0, 2'd0, "s2mk");
    check("s2_wc", 64'(word_count), 64'd3);
    check("s2_rdy_term", 64'(src_ready), 64'(RDY_AFTER_TERM));
    check("s2_cpurst_hold", 64'(cpu_reset_n), 64'd0);
    finish_ok(32'h66, "s2");
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    check("s2_run_busy", 64'(busy), 64'd0);
    check("s2_run_done", 64'(done), 64'd1);
    check("s2_wrcount", 64'(wr_count), 64'd3);
    check("s2_wc_hold", 64'(word_count), 64'd3);

    // src_last terminates, with a gap between words
    do_reset();
    start_load("s3");
    send(32'hA, 1'b0, 1'b1, 2'd0, "s3w0");
    repeat (2) @(negedge clock);
    send(32'hB, 1'b1, 1'b1, 2'd1, "s3w1");
    check("s3_wc", 64'(word_count), 64'd2);
    check("s3_rdy_term", 64'(src_ready), 64'(RDY_AFTER_TERM));
    finish_ok(32'h15, "s3");
    check("s3_wrcount", 64'(wr_count), 64'd2);

    // Overflow at 2**AW words, then recovery from ERROR
    do_reset();
    start_load("s4");
    send(32'h1, 1'b0, 1'b1, 2'd0, "s4w0");
    send(32'h2, 1'b0, 1'b1, 2'd1, "s4w1");
    send(32'h3, 1'b0, 1'b1, 2'd2, "s4w2");
    send(32'h4, 1'b0, 1'b1, 2'd3, "s4w3");
    send(32'h5, 1'b0, 1'b0, 2'd0, "s4ov");
    check("s4_err", 64'(error), 64'd1);
    check("s4_rdy", 64'(src_ready), 64'd0);
    check("s4_busy", 64'(busy), 64'd0);
    check("s4_wc", 64'(word_count), 64'd4);
    check("s4_wrcount", 64'(wr_count), 64'd4);
    start_load("s4r");
    send(32'h77, 1'b0, 1'b1, 2'd0, "s4rw0");
    send(MARK, 1'b0, 1'b0, 2'd0, "s4rmk");
    finish_ok(32'h77, "s4r");

    // End marker as the first word
    do_reset();
    start_load("s5");
    send(MARK, 1'b0, 1'b0, 2'd0, "s5mk");
    check("s5_err", 64'(error), 64'd1);
    repeat (6) @(negedge clock);
    check("s5_wrcount", 64'(wr_count), 64'd0);
    check("s5_cpurst", 64'(cpu_reset_n), 64'd0);
    check("s5_done", 64'(done), 64'd0);

`ifdef BOOT_CHECKSUM_EN
    // Good and bad checksums
    do_reset();
    start_load("s6");
    send(32'h1, 1'b0, 1'b1, 2'd0, "s6w0");
    send(32'h2, 1'b0, 1'b1, 2'd1, "s6w1");
    send(32'h3, 1'b0, 1'b1, 2'd2, "s6w2");
    send(MARK, 1'b0, 1'b0, 2'd0, "s6mk");
    finish_ok(32'h6, "s6");
    do_reset();
    start_load("s6b");
    send(32'h1, 1'b0, 1'b1, 2'd0, "s6bw0");
    send(32'h2, 1'b0, 1'b1, 2'd1, "s6bw1");
    send(32'h3, 1'b0, 1'b1, 2'd2, "s6bw2");
    send(MARK, 1'b0, 1'b0, 2'd0, "s6bmk");
    send(32'h7, 1'b0, 1'b0, 2'd0, "s6bcks");
    check("s6b_err", 64'(error), 64'd1);
    repeat (8) @(negedge clock);
    check("s6b_run", 64'(cpu_run), 64'd0);
    check("s6b_cpurst", 64'(cpu_reset_n), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
